axi_switch_0_ref_example_example_byte_packer: RTL
=================================================

Name: axi_switch_0_ref_example_example_byte_packer

Overview:
Downstream consumer of the 8-bit reg-SRL FIFO output (m_mesg/m_valid/m_ready). Packs the byte stream into 32-bit AXI4-Stream beats with TKEEP and TLAST. TLAST is generated every C_PKT_BEATS beats, or on an idle-timeout flush of a partial beat. The output feeds the switch slave port, so every output is registered.

Parameters:
C_PKT_BEATS, 16, beats per packet; TLAST on beat C_PKT_BEATS-1; legal range 1..256.
C_TIMEOUT, 32, enabled idle cycles with a partial beat pending before a flush; legal range 2..1023.

Ports:
aclk  in  1  clock; all logic on rising edge
areset  in  1  synchronous reset, active-high
aclken  in  1  clock enable; when low, all registers hold and no handshake completes
s_mesg  in  8  byte from FIFO m_mesg
s_valid  in  1  from FIFO m_valid
s_ready  out  1  to FIFO m_ready
m_axis_tdata  out  32  packed beat; byte k in bits [8k+7:8k]
m_axis_tkeep  out  4  byte enables, contiguous from bit 0
m_axis_tlast  out  1  end of packet
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  downstream ready
pkt_done  out  1  one-cycle pulse when a TLAST beat handshakes

Behaviour:
- Reset (areset=1 at a clock edge, regardless of aclken):
  - Accumulator count=0, beat index=0, idle counter=0.
  - m_axis_tvalid=0, tdata=0, tkeep=0, tlast=0, pkt_done=0.
  - s_ready=0 during the reset cycle; s_ready=1 from the first cycle after areset deasserts.
  - Reset mid-packet discards the partial beat and any pending output beat.
- Storage: a 4-byte accumulator (acc, count 0..4) plus one output beat register (the m_axis_* registers).
- Byte accept: s_valid & s_ready & aclken. The byte is written to acc[count], then count increments.
- s_ready = ~rst_hold & ((count!=4) | ~m_axis_tvalid). Registered terms only, so there is no combinational path from m_axis_tready.
- Output register free condition: out_free = ~m_axis_tvalid | m_axis_tready.
- Transfer, acc to output, occurs when out_free & aclken & (count==4 | flush):
  - tdata = acc, with unused bytes forced to 0.
  - tkeep = (1<<count)-1, i.e. 4'hF when count==4.
  - tlast = (beat_idx==C_PKT_BEATS-1) | flush.
  - tvalid=1.
- Beat index after a transfer: reset to 0 if tlast was set; otherwise beat_idx+1.
- Simultaneous transfer and byte accept: the new byte lands in acc[0]; count becomes 1. There is no lost cycle.
- Throughput: with m_axis_tready held at 1, 1 byte/cycle is sustained, giving 1 beat every 4 cycles.
- Output drain: when m_axis_tvalid & m_axis_tready & aclken and no new transfer occurs, tvalid clears to 0.
- AXI-S rule: tdata, tkeep, tlast and tvalid are stable while tvalid=1 and tready=0.
- Idle counter:
  - Increments on each aclken cycle with 0<count<4 and no byte accepted.
  - Clears on byte accept or on transfer.
  - Saturates at C_TIMEOUT.
- Flush: idle counter == C_TIMEOUT. It stays asserted until the transfer occurs, so it waits for out_free.
  - A byte accepted in the same cycle as the flush transfer goes to acc[0] of the next beat.
- Flush is never raised with count==0. An empty accumulator never produces a beat.
- pkt_done: registered pulse one cycle after a handshake where m_axis_tlast=1.
- aclken=0 freezes every register, including the idle counter. Outputs hold their values.

Test Plan:
- Stream bytes 0x00..0x3F continuously, tready=1 -> 16 beats; first beat tdata=0x03020100, tkeep=F; tlast only on beat 16 (tdata=0x3F3E3D3C); pkt_done pulses once; s_ready never drops.
- Send 6 bytes 0xA0..0xA5, then idle -> beat 1 tdata=0xA3A2A1A0, tkeep=F, tlast=0. After exactly 32 idle cycles, beat 2 tdata=0x0000A5A4, tkeep=3, tlast=1.
- Hold tready=0 and send 12 bytes -> one beat pending; s_ready falls after the 8th byte; tdata stays stable. Release tready -> all 3 beats delivered in order, no byte lost or duplicated.
- Timeout expires while the output is stalled (tready=0) -> the flush waits; the partial beat appears with tlast=1 only after the pending beat handshakes. A byte arriving in the flush cycle starts the next beat in byte 0.
- Toggle aclken 0/1 every cycle during the first scenario -> identical output beat sequence, at half rate; the idle timeout counts enabled cycles only.
- Assert areset after 2 bytes and with one beat pending -> next cycle tvalid=0, tkeep=0, s_ready=0. After release, a fresh 4-byte input yields tdata equal to the new bytes only, with beat index restarted (tlast after 16 beats).

Source files
------------

// File: rtl/axi_switch_0_ref_example_example_byte_packer_if.sv
// Byte-in / AXI4-Stream-out bundle for the byte packer.
//   s_mesg, s_valid, s_ready       : byte stream from the reg-SRL FIFO
//   m_axis_tdata/tkeep/tlast/tvalid: packed 32-bit beats toward the switch
//   m_axis_tready                  : downstream ready
//   pkt_done                       : one-cycle pulse after a TLAST handshake
// The packer uses the master modport because it masters the AXI-Stream side.
// The environment (FIFO plus switch, or a testbench) uses the slave modport.
interface axi_switch_0_ref_example_example_byte_packer_if;
    logic [7:0]  s_mesg;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        pkt_done;

    modport master (
        input  s_mesg, s_valid, m_axis_tready,
        output s_ready, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
               m_axis_tvalid, pkt_done
    );

    modport slave (
        output s_mesg, s_valid, m_axis_tready,
        input  s_ready, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
               m_axis_tvalid, pkt_done
    );
endinterface

// File: rtl/axi_switch_0_ref_example_example_byte_packer.sv
// Byte packer: gathers the 8-bit FIFO stream into 32-bit AXI4-Stream beats.
//   aclk    : clock, all logic on the rising edge
//   areset  : synchronous active-high reset
//   aclken  : clock enable; when low, every register holds
//   bus     : byte input and AXI-Stream output (see the _if file)
// A beat leaves when four bytes are gathered. A partial beat leaves after
// C_TIMEOUT enabled idle cycles, and that flush beat always carries TLAST.
// Otherwise TLAST marks every C_PKT_BEATS-th beat.
// There is a 4-byte accumulator plus one output register, so one byte per
// cycle is sustained while the downstream side is ready.
module axi_switch_0_ref_example_example_byte_packer #(
    parameter int C_PKT_BEATS = 16,
    parameter int C_TIMEOUT   = 32
) (
    input  logic aclk,
    input  logic areset,
    input  logic aclken,
    axi_switch_0_ref_example_example_byte_packer_if.master bus
);

    localparam int IDLE_W = 10;
    localparam int BEAT_W = 8;
    localparam logic [IDLE_W-1:0] TIMEOUT_V  = IDLE_W'(C_TIMEOUT);
    localparam logic [BEAT_W-1:0] LAST_IDX_V = BEAT_W'(C_PKT_BEATS - 1);

    // Keep mask for a beat carrying n bytes: contiguous from byte 0.
    function automatic logic [3:0] keep_mask(input logic [2:0] n);
        logic [3:0] k;
        case (n)
            3'd0:    k = 4'h0;
            3'd1:    k = 4'h1;
            3'd2:    k = 4'h3;
            3'd3:    k = 4'h7;
            3'd4:    k = 4'hF;
            default: k = 4'h0;
        endcase
        return k;
    endfunction

    // Expand a keep mask into a bit mask, so that unused bytes read as zero.
    function automatic logic [31:0] byte_mask(input logic [3:0] k);
        return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
    endfunction

    logic [31:0]       acc_r;
    logic [2:0]        count_r;
    logic [BEAT_W-1:0] beat_idx_r;
    logic [IDLE_W-1:0] idle_r;
    logic              rst_hold_r;
    logic [31:0]       tdata_r;
    logic [3:0]        tkeep_r;
    logic              tlast_r;
    logic              tvalid_r;
    logic              pkt_done_r;

    logic              s_ready_s;
    logic              accept_s;
    logic              out_free_s;
    logic              flush_s;
    logic              xfer_s;
    logic              last_s;
    logic [31:0]       acc_nxt_s;
    logic [2:0]        count_nxt_s;
    logic [BEAT_W-1:0] beat_idx_nxt_s;
    logic [IDLE_W-1:0] idle_nxt_s;
    logic [31:0]       tdata_nxt_s;
    logic [3:0]        tkeep_nxt_s;
    logic              tlast_nxt_s;
    logic              tvalid_nxt_s;
    logic              pkt_done_nxt_s;

    // Handshake terms and next-state values for the accumulator and output beat.
    always_comb begin
        // s_ready uses registered terms only, so m_axis_tready has no
        // combinational path to the FIFO side.
        s_ready_s  = ~rst_hold_r & ((count_r != 3'd4) | ~tvalid_r);
        accept_s   = bus.s_valid & s_ready_s & aclken;
        out_free_s = ~tvalid_r | bus.m_axis_tready;
        // The idle counter only advances with a partial beat pending.
        // The count guard is a second fence against an empty flush.
        flush_s    = (idle_r == TIMEOUT_V) & (count_r != 3'd0);
        xfer_s     = out_free_s & aclken & ((count_r == 3'd4) | flush_s);
        last_s     = (beat_idx_r == LAST_IDX_V) | flush_s;

        acc_nxt_s      = acc_r;
        count_nxt_s    = count_r;
        beat_idx_nxt_s = beat_idx_r;
        idle_nxt_s     = idle_r;
        tdata_nxt_s    = tdata_r;
        tkeep_nxt_s    = tkeep_r;
        tlast_nxt_s    = tlast_r;
        tvalid_nxt_s   = tvalid_r;
        pkt_done_nxt_s = tvalid_r & bus.m_axis_tready & tlast_r;

        // Accumulator. A byte taken in the transfer cycle starts the next beat.
        if (xfer_s) begin
            if (accept_s) begin
                acc_nxt_s   = {24'd0, bus.s_mesg};
                count_nxt_s = 3'd1;
            end else begin
                acc_nxt_s   = 32'd0;
                count_nxt_s = 3'd0;
            end
        end else if (accept_s) begin
            acc_nxt_s[{count_r[1:0], 3'b000} +: 8] = bus.s_mesg;
            count_nxt_s = count_r + 3'd1;
        end else begin
            count_nxt_s = count_r;
        end

        // Output register: load a new beat, or drain it once it has handshaken.
        if (xfer_s) begin
            tdata_nxt_s    = acc_r & byte_mask(keep_mask(count_r));
            tkeep_nxt_s    = keep_mask(count_r);
            tlast_nxt_s    = last_s;
            tvalid_nxt_s   = 1'b1;
            beat_idx_nxt_s = last_s ? {BEAT_W{1'b0}} : beat_idx_r + {{(BEAT_W-1){1'b0}}, 1'b1};
        end else if (tvalid_r & bus.m_axis_tready & aclken) begin
            tvalid_nxt_s = 1'b0;
        end else begin
            tvalid_nxt_s = tvalid_r;
        end

        // Idle counter: counts enabled cycles with a partial beat and no input.
        // It saturates so that flush stays up while the output is stalled.
        if (accept_s | xfer_s) begin
            idle_nxt_s = {IDLE_W{1'b0}};
        end else if (aclken & (count_r != 3'd0) & (count_r != 3'd4) & (idle_r != TIMEOUT_V)) begin
            idle_nxt_s = idle_r + {{(IDLE_W-1){1'b0}}, 1'b1};
        end else begin
            idle_nxt_s = idle_r;
        end
    end

    // Reset-hold flag: keeps s_ready low during the reset cycle only.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rst_hold_r <= 1'b1;
        end else begin
            rst_hold_r <= 1'b0;
        end
    end

    // Main state registers: frozen while aclken is low, cleared by areset.
    always_ff @(posedge aclk) begin
        if (areset) begin
            acc_r      <= 32'd0;
            count_r    <= 3'd0;
            beat_idx_r <= {BEAT_W{1'b0}};
            idle_r     <= {IDLE_W{1'b0}};
            tdata_r    <= 32'd0;
            tkeep_r    <= 4'd0;
            tlast_r    <= 1'b0;
            tvalid_r   <= 1'b0;
            pkt_done_r <= 1'b0;
        end else if (aclken) begin
            acc_r      <= acc_nxt_s;
            count_r    <= count_nxt_s;
            beat_idx_r <= beat_idx_nxt_s;
            idle_r     <= idle_nxt_s;
            tdata_r    <= tdata_nxt_s;
            tkeep_r    <= tkeep_nxt_s;
            tlast_r    <= tlast_nxt_s;
            tvalid_r   <= tvalid_nxt_s;
            pkt_done_r <= pkt_done_nxt_s;
        end else begin
            acc_r      <= acc_r;
            count_r    <= count_r;
            beat_idx_r <= beat_idx_r;
            idle_r     <= idle_r;
            tdata_r    <= tdata_r;
            tkeep_r    <= tkeep_r;
            tlast_r    <= tlast_r;
            tvalid_r   <= tvalid_r;
            pkt_done_r <= pkt_done_r;
        end
    end

    assign bus.s_ready       = s_ready_s;
    assign bus.m_axis_tdata  = tdata_r;
    assign bus.m_axis_tkeep  = tkeep_r;
    assign bus.m_axis_tlast  = tlast_r;
    assign bus.m_axis_tvalid = tvalid_r;
    assign bus.pkt_done      = pkt_done_r;

endmodule
